// File: rtl/ram_fifo_ctrl_if.sv
// Bus bundle between the FIFO user, ram_fifo_ctrl and the 16x8 dual-port RAM.
// RAM_FIFO_ERR_EN adds the sticky overflow/underflow flags.
interface ram_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  mem_w_en;
  logic [ADDR_WIDTH-1:0] mem_w_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_WIDTH-1:0] mem_r_data;
`ifdef RAM_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // slave is the controller; master is its surroundings (FIFO user plus RAM)
  modport slave (
    input  wr_en, wr_data, rd_en, mem_r_data,
    output full, rd_data, rd_valid, empty, count,
    output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
`ifdef RAM_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

  modport master (
    output wr_en, wr_data, rd_en, mem_r_data,
    input  full, rd_data, rd_valid, empty, count,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
`ifdef RAM_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller fronting a dual-port RAM with 1-cycle registered read.
// Optional macro RAM_FIFO_ERR_EN adds sticky overflow/underflow flags.
module ram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  fifo_if
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_rd_valid;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Accept decisions use the registered flags; reset suppresses both strobes
  assign w_push_ok = fifo_if.wr_en & ~r_full  & ~rst;
  assign w_pop_ok  = fifo_if.rd_en & ~r_empty & ~rst;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count    <= w_count_next;
      r_empty    <= (w_count_next == CW'(0));
      r_full     <= (w_count_next == CW'(DEPTH));
      r_rd_valid <= w_pop_ok;
    end
  end

  // RAM registers read data on the pop edge, so it lines up with r_rd_valid
  assign w_rd_data          = fifo_if.mem_r_data;
  assign fifo_if.rd_data    = w_rd_data;
  assign fifo_if.rd_valid   = r_rd_valid;
  assign fifo_if.empty      = r_empty;
  assign fifo_if.full       = r_full;
  assign fifo_if.count      = r_count;
  assign fifo_if.mem_w_en   = w_push_ok;
  assign fifo_if.mem_w_addr = r_wr_ptr;
  assign fifo_if.mem_w_data = fifo_if.wr_data;
  assign fifo_if.mem_r_en   = w_pop_ok;
  assign fifo_if.mem_r_addr = r_rd_ptr;

`ifdef RAM_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky until reset; rejected requests still leave state untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (fifo_if.wr_en & r_full)  r_overflow  <= 1'b1;
      if (fifo_if.rd_en & r_empty) r_underflow <= 1'b1;
    end
  end

  assign fifo_if.overflow  = r_overflow;
  assign fifo_if.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 16x8 RAM and a read scoreboard.
// Honors RAM_FIFO_ERR_EN for the overflow/underflow checks.
module tb_ram_fifo_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .fifo_if(bus));

  // Behavioural dual-port RAM with registered read
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_w_en) ram[bus.mem_w_addr] <= bus.mem_w_data;
    if (bus.mem_r_en) ram_q <= ram[bus.mem_r_addr];
  end
  assign bus.mem_r_data = ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] mon_d;
  logic          t_rst, t_wr, t_rd;
  logic [DW-1:0] t_wd;

  task automatic apply(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
    rst = r; bus.wr_en = w; bus.wr_data = d; bus.rd_en = rd;
    t_rst = r; t_wr = w; t_wd = d; t_rd = rd;
    #1;
  endtask

  // Advance one edge and update the reference FIFO model with what it accepted
  task automatic tick();
    logic p_ok, q_ok;
    p_ok = !t_rst && t_wr && (model_q.size() < DEPTH);
    q_ok = !t_rst && t_rd && (model_q.size() > 0);
    @(posedge clk);
    if (t_rst) begin
      model_q.delete();
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      if (q_ok) exp_q.push_back(model_q.pop_front());
      if (p_ok) model_q.push_back(t_wd);
      exp_valid = q_ok;
    end
    #1;
  endtask

  // Scoreboard: every cycle rd_valid must match the model; valid data pops in order
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (bus.rd_valid !== exp_valid) $display("FAIL rd_valid: got %b want %b at %0t", bus.rd_valid, exp_valid, $time);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rd_data: scoreboard empty at %0t", $time);
        else begin
          mon_d = exp_q.pop_front();
          if (bus.rd_data !== mon_d) $display("FAIL rd_data: got %02h want %02h at %0t", bus.rd_data, mon_d, $time);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    apply(1'b1, 1'b0, '0, 1'b0); tick(); tick();
    mon_en = 1'b1;
    apply(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
    n_checks++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else n_pass++;
`ifdef RAM_FIFO_ERR_EN
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL reset_err: got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
`endif
    repeat (5) begin
      n_checks++; if ({bus.mem_w_en, bus.mem_r_en} !== 2'b00) $display("FAIL idle_strobes: got %b want 00", {bus.mem_w_en, bus.mem_r_en}); else n_pass++;
      tick();
      n_checks++; if ({bus.empty, bus.full, bus.count} !== {2'b10, 5'd0}) $display("FAIL idle_state: got %b want 1000000", {bus.empty, bus.full, bus.count}); else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b1, vals[i], 1'b0); tick(); end
    n_checks++; if (bus.count !== 5'd3) $display("FAIL basic_count3: got %0d want 3", bus.count); else n_pass++;
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b0, '0, 1'b1); tick(); end
    apply(1'b0, 1'b0, '0, 1'b0); tick();
    n_checks++; if ({bus.empty, bus.count} !== {1'b1, 5'd0}) $display("FAIL basic_drained: got %b want 100000", {bus.empty, bus.count}); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin apply(1'b0, 1'b1, DW'(i), 1'b0); tick(); end
    apply(1'b0, 1'b1, 8'hFF, 1'b0);
    n_checks++; if ({bus.full, bus.count} !== {1'b1, 5'd16}) $display("FAIL fill_full: got %b want 110000", {bus.full, bus.count}); else n_pass++;
    n_checks++; if (bus.mem_w_en !== 1'b0) $display("FAIL push_full_wen: got %b want 0", bus.mem_w_en); else n_pass++;
    tick();
    n_checks++; if ({bus.full, bus.count} !== {1'b1, 5'd16}) $display("FAIL push_full_state: got %b want 110000", {bus.full, bus.count}); else n_pass++;
`ifdef RAM_FIFO_ERR_EN
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL overflow: got %b want 1", bus.overflow); else n_pass++;
`endif
    for (int i = 0; i < 16; i++) begin apply(1'b0, 1'b0, '0, 1'b1); tick(); end
    apply(1'b0, 1'b0, '0, 1'b0); tick();
    n_checks++; if ({bus.empty, bus.count} !== {1'b1, 5'd0}) $display("FAIL fill_drained: got %b want 100000", {bus.empty, bus.count}); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) begin apply(1'b0, 1'b1, DW'(8'h40 + k), 1'b0); tick(); end
    for (int k = 3; k < 40; k++) begin
      apply(1'b0, 1'b1, DW'(8'h40 + k), 1'b1); tick();
      n_checks++; if (bus.count !== 5'd3) $display("FAIL wrap_count k=%0d: got %0d want 3", k, bus.count); else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin apply(1'b0, 1'b0, '0, 1'b1); tick(); end
    apply(1'b0, 1'b0, '0, 1'b0); tick();
    n_checks++; if (bus.count !== 5'd0) $display("FAIL wrap_drained: got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 8'h55, 1'b1);
    n_checks++; if ({bus.mem_w_en, bus.mem_r_en} !== 2'b10) $display("FAIL pp_empty_strobes: got %b want 10", {bus.mem_w_en, bus.mem_r_en}); else n_pass++;
    tick();
    n_checks++; if ({bus.empty, bus.count} !== {1'b0, 5'd1}) $display("FAIL pp_empty_count: got %b want 000001", {bus.empty, bus.count}); else n_pass++;
    apply(1'b0, 1'b0, '0, 1'b1); tick();
    for (int i = 0; i < 16; i++) begin apply(1'b0, 1'b1, DW'(8'h80 + i), 1'b0); tick(); end
    apply(1'b0, 1'b1, 8'hEE, 1'b1);
    n_checks++; if ({bus.mem_w_en, bus.mem_r_en} !== 2'b01) $display("FAIL pp_full_strobes: got %b want 01", {bus.mem_w_en, bus.mem_r_en}); else n_pass++;
    tick();
    n_checks++; if ({bus.full, bus.count} !== {1'b0, 5'd15}) $display("FAIL pp_full_count: got %b want 001111", {bus.full, bus.count}); else n_pass++;
    for (int i = 0; i < 10; i++) begin apply(1'b0, 1'b0, '0, 1'b1); tick(); end
    apply(1'b0, 1'b1, 8'h77, 1'b1);
    n_checks++; if ({bus.mem_w_en, bus.mem_r_en} !== 2'b11) $display("FAIL pp_mid_strobes: got %b want 11", {bus.mem_w_en, bus.mem_r_en}); else n_pass++;
    tick();
    n_checks++; if (bus.count !== 5'd5) $display("FAIL pp_mid_count: got %0d want 5", bus.count); else n_pass++;
    for (int i = 0; i < 5; i++) begin apply(1'b0, 1'b0, '0, 1'b1); tick(); end
    apply(1'b0, 1'b0, '0, 1'b0); tick();
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL pp_drained: got %b want 1", bus.empty); else n_pass++;
  endtask

  task automatic test_pop_empty_reset();
    apply(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bus.mem_r_en !== 1'b0) $display("FAIL pop_empty_ren: got %b want 0", bus.mem_r_en); else n_pass++;
    tick();
`ifdef RAM_FIFO_ERR_EN
    n_checks++; if (bus.underflow !== 1'b1) $display("FAIL underflow: got %b want 1", bus.underflow); else n_pass++;
`endif
    apply(1'b0, 1'b1, 8'h11, 1'b0); tick();
    apply(1'b0, 1'b1, 8'h22, 1'b0); tick();
    apply(1'b0, 1'b0, '0, 1'b1); tick();
    apply(1'b1, 1'b1, 8'h99, 1'b1);
    n_checks++; if ({bus.mem_w_en, bus.mem_r_en} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {bus.mem_w_en, bus.mem_r_en}); else n_pass++;
    tick();
    n_checks++; if ({bus.rd_valid, bus.empty, bus.full, bus.count} !== {3'b010, 5'd0}) $display("FAIL rst_state: got %b want 01000000", {bus.rd_valid, bus.empty, bus.full, bus.count}); else n_pass++;
`ifdef RAM_FIFO_ERR_EN
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL rst_err: got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
`endif
    apply(1'b0, 1'b0, '0, 1'b0); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_wrap();
    test_back_to_back();
    test_pop_empty_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
